// File: rtl/ofdm_burst_framer.sv
// ---------------------------------------------------------------------------
// ofdm_burst_framer : buffers 12 OFDM symbol bodies, streams a CP-prefixed burst
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ofdm_burst_framer #(
  parameter int FFT_POINT = 64,
  parameter int CP_NUM    = 16,
  parameter int NUM_BODY  = 12,
  parameter int DW        = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          wren,
  input  logic [9:0]    wr_addr,
  input  logic          start,
  output logic          buf_ready,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          tx_done,
  output logic          wr_drop
);

  localparam int AW       = 10;
  localparam int SLOT_LEN = FFT_POINT + CP_NUM;
  localparam int NUM_SLOT = 14;
  localparam int DEPTH    = NUM_BODY * FFT_POINT;
  localparam int CP_BASE  = FFT_POINT - CP_NUM;
  localparam int SW       = $clog2(SLOT_LEN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    slot_q, slot_d;
  logic [SW-1:0] samp_q, samp_d;
  logic          issued_all_q, issued_all_d;
  logic          rd_valid_q, rd_valid_d;
  logic          rd_zero_q, rd_zero_d;
  logic [DW-1:0] skid0_q, skid0_d;
  logic [DW-1:0] skid1_q, skid1_d;
  logic [1:0]    skid_cnt_q, skid_cnt_d;
  logic          wr_drop_q, wr_drop_d;

  logic [DW-1:0] mem [0:DEPTH-1];
  logic [DW-1:0] ram_rd_q;

  logic          guard;
  logic [3:0]    body;
  logic [AW-1:0] offs;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic          issue;
  logic          pop;
  logic [1:0]    occ;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] e0, e1;

  // Slot map: two sync bodies, guard, body2, guard, body3, then eight data bodies
  always_comb begin
    guard = 1'b0;
    body  = 4'd0;
    case (slot_q)
      4'd0:    body  = 4'd0;
      4'd1:    body  = 4'd1;
      4'd2:    guard = 1'b1;
      4'd3:    body  = 4'd2;
      4'd4:    guard = 1'b1;
      4'd5:    body  = 4'd3;
      default: body  = slot_q - 4'd2;
    endcase
  end

  always_comb begin
    if (samp_q < SW'(CP_NUM)) offs = AW'(CP_BASE) + AW'(samp_q);
    else                      offs = AW'(samp_q) - AW'(CP_NUM);
    rd_addr = AW'(body) * AW'(FFT_POINT) + offs;
  end

  assign buf_ready  = (state_q == ST_IDLE);
  assign tx_done    = (state_q == ST_DONE);
  assign wr_drop    = wr_drop_q;
  assign rd_data    = rd_zero_q ? '0 : ram_rd_q;
  assign dout_valid = (skid_cnt_q != 2'd0) || rd_valid_q;
  assign dout       = (skid_cnt_q != 2'd0) ? skid0_q : (rd_valid_q ? rd_data : '0);
  assign pop        = dout_valid && dout_ready;
  assign occ        = skid_cnt_q + {1'b0, rd_valid_q};
  // A read is launched only if the skid can absorb it even under a full stall
  assign issue      = (state_q == ST_SEND) && !issued_all_q && (occ < 2'd2);
  assign ram_we     = (state_q == ST_IDLE) && wren && (wr_addr < AW'(DEPTH));
  assign ram_addr   = (state_q == ST_IDLE) ? wr_addr : rd_addr;

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    samp_d       = samp_q;
    issued_all_d = issued_all_q;
    wr_drop_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        wr_drop_d = wren && (wr_addr >= AW'(DEPTH));
        if (start) begin
          state_d      = ST_SEND;
          slot_d       = 4'd0;
          samp_d       = '0;
          issued_all_d = 1'b0;
        end
      end
      ST_SEND: begin
        wr_drop_d = wren || start;
        if (issue) begin
          if (samp_q == SW'(SLOT_LEN - 1)) begin
            samp_d = '0;
            if (slot_q == 4'(NUM_SLOT - 1)) issued_all_d = 1'b1;
            else                              slot_d       = slot_q + 4'd1;
          end else begin
            samp_d = samp_q + SW'(1);
          end
        end
        if (issued_all_q && pop && (occ == 2'd1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        wr_drop_d = wren || start;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Skid as an in-order list: stored entries first, then the RAM word landing now
  always_comb begin
    rd_valid_d = issue;
    rd_zero_d  = guard;
    e0         = (skid_cnt_q != 2'd0) ? skid0_q : rd_data;
    e1         = (skid_cnt_q == 2'd2) ? skid1_q : rd_data;
    skid1_d    = skid1_q;
    if (pop) begin
      skid0_d    = e1;
      skid_cnt_d = occ - 2'd1;
    end else begin
      skid0_d    = e0;
      skid1_d    = e1;
      skid_cnt_d = occ;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      slot_q       <= 4'd0;
      samp_q       <= '0;
      issued_all_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_zero_q    <= 1'b0;
      skid0_q      <= '0;
      skid1_q      <= '0;
      skid_cnt_q   <= 2'd0;
      wr_drop_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      samp_q       <= samp_d;
      issued_all_q <= issued_all_d;
      rd_valid_q   <= rd_valid_d;
      rd_zero_q    <= rd_zero_d;
      skid0_q      <= skid0_d;
      skid1_q      <= skid1_d;
      skid_cnt_q   <= skid_cnt_d;
      wr_drop_q    <= wr_drop_d;
    end
  end

  // Single-port buffer; contents intentionally not reset
  always_ff @(posedge clk) begin
    if (ram_we)     mem[ram_addr] <= din;
    else if (issue) ram_rd_q      <= mem[ram_addr];
  end

endmodule

`default_nettype wire

// File: tb/tb_ofdm_burst_framer.sv
// ---------------------------------------------------------------------------
// tb_ofdm_burst_framer : directed bench for the OFDM burst framer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ofdm_burst_framer;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] din;
  logic          wren;
  logic [9:0]    wr_addr;
  logic          start;
  logic          buf_ready;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          tx_done;
  logic          wr_drop;

  ofdm_burst_framer #(.FFT_POINT(64), .CP_NUM(16), .NUM_BODY(12), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .wren       (wren),
    .wr_addr    (wr_addr),
    .start      (start),
    .buf_ready  (buf_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .tx_done    (tx_done),
    .wr_drop    (wr_drop)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  logic [DW-1:0] mdl [0:767];
  logic [DW-1:0] got [0:1119];

  int acc, dat_err, stab_err, first_v, last_acc, done_at, drop_cnt, vcnt;
  bit done_seen, done_valid, busy1, after_ready, after_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_at(input int i);
    int sl, s, b;
    sl = i / 80;
    s  = i % 80;
    if (sl == 2 || sl == 4) return '0;
    if (sl < 2)       b = sl;
    else if (sl == 3) b = 2;
    else if (sl == 5) b = 3;
    else              b = sl - 2;
    return mdl[b * 64 + ((s < 16) ? (48 + s) : (s - 16))];
  endfunction

  // Runs one burst. Entry: pre=0 -> at posedge+1; pre=1 -> at negedge with start already high.
  task automatic burst(input bit rnd, input bit pre, input bit chain, input int abort_at, input bit poke);
    int poke_st;
    bit pv;
    logic [DW-1:0] pd;
    poke_st = 0; pv = 1'b0; pd = '0;
    acc = 0; dat_err = 0; stab_err = 0; first_v = -1; last_acc = -1; done_at = -1;
    drop_cnt = 0; vcnt = 0; done_seen = 0; done_valid = 0; busy1 = 1; after_ready = 0; after_done = 0;
    if (!pre) begin
      start = 1'b1;
      dout_ready = 1'b1;
      @(negedge clk);
    end
    for (int k = 0; k < 6000; k++) begin
      if (k == 1) busy1 = buf_ready;
      if (done_seen && k == done_at + 1) begin
        after_ready = buf_ready;
        after_done  = tx_done;
        break;
      end
      if (pv && (!dout_valid || dout !== pd)) stab_err++;
      if (dout_valid) begin
        vcnt++;
        if (first_v < 0) first_v = k;
      end
      if (tx_done && !done_seen) begin
        done_seen  = 1'b1;
        done_at    = k;
        done_valid = dout_valid;
      end
      if (wr_drop) drop_cnt++;
      if (dout_valid && dout_ready) begin
        if (acc < 1120) begin
          got[acc] = dout;
          if (dout !== exp_at(acc)) dat_err++;
        end else begin
          dat_err++;
        end
        acc++;
        last_acc = k;
      end
      pv = dout_valid && !dout_ready;
      pd = dout;
      @(posedge clk); #1;
      if (k == 0) begin
        start = 1'b0;
        wren  = 1'b0;
      end
      dout_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke && poke_st == 0 && acc >= 560) begin
        wren = 1'b1; wr_addr = 10'd5; din = 8'hEE; poke_st = 1;
      end else if (poke_st == 1) begin
        wren = 1'b0; start = 1'b1; poke_st = 2;
      end else if (poke_st == 2) begin
        start = 1'b0; poke_st = 3;
      end
      if (abort_at >= 0 && acc == abort_at) break;
      @(negedge clk);
    end
    if (chain) begin
      start = 1'b1;
      dout_ready = 1'b1;
    end
  endtask

  task automatic check_full(input string tag);
    chk({tag, "_done_seen"}, 32'(done_seen), 32'd1);
    chk({tag, "_accepted"}, 32'(acc), 32'd1120);
    chk({tag, "_data_err"}, 32'(dat_err), 32'd0);
    chk({tag, "_done_valid_low"}, 32'(done_valid), 32'd0);
    chk({tag, "_done_after_last"}, 32'(done_at), 32'(last_acc + 1));
    chk({tag, "_ready_after_done"}, 32'(after_ready), 32'd1);
    chk({tag, "_done_one_cycle"}, 32'(after_done), 32'd0);
  endtask

  int n;

  initial begin
    rst = 1'b1; din = '0; wren = 1'b0; wr_addr = '0; start = 1'b0; dout_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_buf_ready", 32'(buf_ready), 32'd1);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_dout_valid", 32'(dout_valid), 32'd0);
    chk("rst_tx_done", 32'(tx_done), 32'd0);
    chk("rst_wr_drop", 32'(wr_drop), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Ramp fill
    n = 0;
    for (int a = 0; a < 768; a++) begin
      wren = 1'b1; wr_addr = 10'(a); din = 8'(a); mdl[a] = 8'(a);
      @(negedge clk);
      if (wr_drop) n++;
      @(posedge clk); #1;
    end
    wren = 1'b0;
    @(negedge clk);
    if (wr_drop) n++;
    chk("fill_no_drop", 32'(n), 32'd0);
    @(posedge clk); #1;

    // Out-of-range write in IDLE
    wren = 1'b1; wr_addr = 10'd800; din = 8'h55;
    @(posedge clk); #1;
    wren = 1'b0;
    @(negedge clk);
    chk("bad_addr_drop", 32'(wr_drop), 32'd1);
    chk("bad_addr_ready", 32'(buf_ready), 32'd1);
    @(posedge clk); #1;

    // Continuous burst, chained into a back-to-back burst
    burst(1'b0, 1'b0, 1'b1, -1, 1'b0);
    check_full("cont");
    chk("cont_busy", 32'(busy1), 32'd0);
    chk("cont_first_valid", 32'(first_v), 32'd2);
    chk("cont_valid_cycles", 32'(vcnt), 32'd1120);
    chk("cont_last_beat", 32'(last_acc), 32'd1121);
    chk("cont_no_drop", 32'(drop_cnt), 32'd0);
    chk("s0", 32'(got[0]), 32'd48);
    chk("s15", 32'(got[15]), 32'd63);
    chk("s16", 32'(got[16]), 32'd0);
    chk("s79", 32'(got[79]), 32'd63);
    chk("s80", 32'(got[80]), 32'd112);
    chk("s160_guard", 32'(got[160]), 32'd0);
    chk("s239_guard", 32'(got[239]), 32'd0);
    chk("s240", 32'(got[240]), 32'hB0);
    chk("s1119", 32'(got[1119]), 32'hFF);

    burst(1'b0, 1'b1, 1'b0, -1, 1'b0);
    check_full("b2b");
    chk("b2b_first_valid", 32'(first_v), 32'd2);
    chk("b2b_valid_cycles", 32'(vcnt), 32'd1120);

    // Random backpressure
    @(posedge clk); #1;
    burst(1'b1, 1'b0, 1'b0, -1, 1'b0);
    check_full("rnd");
    chk("rnd_stable", 32'(stab_err), 32'd0);

    // Write and start strobes during slot 7
    @(posedge clk); #1;
    burst(1'b0, 1'b0, 1'b0, -1, 1'b1);
    check_full("poke");
    chk("poke_drops", 32'(drop_cnt), 32'd2);
    @(posedge clk); #1;
    burst(1'b0, 1'b0, 1'b0, -1, 1'b0);
    check_full("after_poke");
    chk("after_poke_addr5", 32'(got[21]), 32'd5);

    // Simultaneous write and start in IDLE
    @(posedge clk); #1;
    wren = 1'b1; wr_addr = 10'd48; din = 8'h99; mdl[48] = 8'h99;
    burst(1'b0, 1'b0, 1'b0, -1, 1'b0);
    check_full("wr_start");
    chk("wr_start_s0", 32'(got[0]), 32'h99);
    @(posedge clk); #1;
    wren = 1'b1; wr_addr = 10'd48; din = 8'd48; mdl[48] = 8'd48;
    @(posedge clk); #1;
    wren = 1'b0;

    // Reset mid-burst at sample 500
    burst(1'b0, 1'b0, 1'b0, 500, 1'b0);
    chk("abort_at", 32'(acc), 32'd500);
    rst = 1'b1;
    #1;
    chk("abort_valid", 32'(dout_valid), 32'd0);
    chk("abort_dout", 32'(dout), 32'd0);
    chk("abort_ready", 32'(buf_ready), 32'd1);
    n = 0;
    repeat (2) begin
      @(negedge clk);
      if (tx_done) n++;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (tx_done || dout_valid) n++;
      @(posedge clk); #1;
    end
    chk("abort_quiet", 32'(n), 32'd0);
    burst(1'b0, 1'b0, 1'b0, -1, 1'b0);
    check_full("resend");
    chk("resend_s0", 32'(got[0]), 32'd48);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ofdm_burst_framer.md
# ofdm_burst_framer

Transmit-side OFDM burst framer: buffers 12 time-domain symbol bodies (64 × 8-bit samples each) from the IFFT stage, then streams one 1120-sample burst: a 6-slot preamble followed by 8 data symbols, with a cyclic prefix on every symbol. The burst layout is exactly what the receive-side time synchronizer expects. Sits between the IFFT/Hermitian packer and the DAC/LED driver. Its `tx_done` pulse is what that synchronizer consumes.

## Interface
- `FFT_POINT`, 64, samples per symbol body
- `CP_NUM`, 16, cyclic-prefix length (last CP_NUM body samples)
- `NUM_BODY`, 12, stored symbol bodies (4 channel-est + 8 data)
- `DW`, 8, sample width
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `din`  in  DW  sample to buffer
- `wren`  in  1  write strobe for `din`
- `wr_addr`  in  10  buffer address, 0..767 (body k occupies k*64..k*64+63)
- `start`  in  1  single-cycle request to send buffered burst
- `buf_ready`  out  1  high in IDLE; writes/start accepted
- `dout`  out  DW  burst sample
- `dout_valid`  out  1  `dout` holds a valid sample
- `dout_ready`  in  1  downstream accepts sample when high with `dout_valid`
- `tx_done`  out  1  one-cycle pulse after last burst sample accepted
- `wr_drop`  out  1  one-cycle pulse: write or start rejected (busy, or address ≥ 768)

## Operation
- Burst = 14 slots × 80 samples = 1120. Each slot = CP (body samples 48..63), then body samples 0..63.
- Slot map: S0=body0, S1=body1 (time-sync pair, also channel est), S2=guard, S3=body2, S4=guard, S5=body3, S6..S13=body4..body11 (data).
- Guard slot: 80 samples of 0x00, no buffer read.
- Read address for body b, slot sample s (0..79): b*64 + (s<16 ? 48+s : s-16).
- States:
  - IDLE: `buf_ready`=1; `wren` writes the buffer; `start` → SEND.
  - SEND: slot counter 0..13, sample counter 0..79; advance on each accepted sample. After sample 1119 is accepted → DONE.
  - DONE: one cycle, `tx_done`=1 → IDLE.
- No check that all 768 locations were written; stale contents are sent as-is.
- In SEND/DONE: `wren` or `start` → `wr_drop` pulse, buffer unchanged. In IDLE, `wren` with `wr_addr` ≥ 768 → `wr_drop`, no write.
- Simultaneous `wren` and `start` in IDLE: write completes, burst starts. The written sample is visible to the burst.
- Buffer: single-port synchronous-read RAM, 768×DW, 1-cycle read latency. Read pipeline with a 2-entry skid so `dout_ready` stalls never drop or duplicate samples.
- Buffer contents survive reset, but are not guaranteed.

## Timing
- Reset values: `buf_ready`=1 (state IDLE), `dout`=0, `dout_valid`=0, `tx_done`=0, `wr_drop`=0, counters 0.
- Reset mid-burst: output stream aborts immediately, no `tx_done`, IDLE after release.
- `start` accepted at edge N: `buf_ready`=0 from N+1; first `dout_valid` at N+2.
- With `dout_ready` held high: one sample per cycle, 1120 consecutive valid cycles.
- Handshake: `dout`/`dout_valid` hold stable while `dout_valid`=1 and `dout_ready`=0. Transfer occurs on an edge where both are high.
- `tx_done` pulses the cycle after the final transfer; `dout_valid`=0 that cycle. `buf_ready`=1 the following cycle.
- `wr_drop` is asserted the cycle after the offending strobe.
- Counters wrap: sample 79 → 0 with slot+1. Slot 13/sample 79 is terminal; nothing wraps past it.

## Test plan
- Ramp fill (`mem[a]=a[7:0]`), `start`, `dout_ready`=1:
  - samples 0..15 = 48..63, then 16..79 = 0..63;
  - samples 160..239 all 0;
  - sample 240 = 0xB0 (body2, s=0);
  - exactly 1120 valid beats, then `tx_done` one cycle later.
- Random `dout_ready` (50%) on the same burst: accepted sequence identical to the continuous case; no sample dropped or repeated; `dout` stable during stalls.
- `wren` and `start` at slot 7 during SEND: `wr_drop` pulses twice, burst unaffected, buffer unchanged on the next burst.
- `wren` with `wr_addr`=800 in IDLE → `wr_drop`, no write, `buf_ready` stays 1.
- `rst` asserted mid-burst at sample 500:
  - outputs zero immediately, no `tx_done`;
  - after release, `start` resends the full burst from sample 0.
- Back-to-back: `start` on the cycle `buf_ready` rises after `tx_done` → second burst begins 2 cycles later, 1120 samples.
